// File: rtl/classify_accum_bank_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | classify_accum_bank_if : point-in and drain-out handshakes of the bank   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface classify_accum_bank_if #(
   parameter int DIMS         = 7,
   parameter int COORD_W      = 13,
   parameter int ACCUM_CORD_W = 22,
   parameter int CNT_W        = 10,
   parameter int IDX_W        = 4
);
   logic                          in_valid;
   logic                          in_ready;
   logic [IDX_W-1:0]              in_index;
   logic [DIMS*COORD_W-1:0]       in_point;
   logic                          out_valid;
   logic                          out_ready;
   logic [IDX_W-1:0]              out_index;
   logic [DIMS*ACCUM_CORD_W-1:0]  out_accum;
   logic [CNT_W-1:0]              out_count;
   logic                          out_last;

   modport master (
      output in_valid, in_index, in_point, out_ready,
      input  in_ready, out_valid, out_index, out_accum, out_count, out_last
   );

   modport slave (
      input  in_valid, in_index, in_point, out_ready,
      output in_ready, out_valid, out_index, out_accum, out_count, out_last
   );
endinterface
`default_nettype wire

// File: rtl/classify_accum_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | classify_accum_bank : saturating per-centroid sum/count bank with drain  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module classify_accum_bank #(
   parameter int CENTROID_NUM = 8,
   parameter int DIMS         = 7,
   parameter int COORD_W      = 13,
   parameter int ACCUM_CORD_W = 22,
   parameter int CNT_W        = 10,
   parameter int IDX_W        = 4
) (
   input  wire logic               clk,
   input  wire logic               rst,
   classify_accum_bank_if.slave    bus,
   input  wire logic               clear,
   input  wire logic               drain_req,
   input  wire logic               drain_clear,
   output logic [CENTROID_NUM-1:0] ovf_flags,
   output logic                    idx_err,
   output logic                    busy
);
   localparam logic [IDX_W:0]        c_num     = (IDX_W+1)'(CENTROID_NUM);
   localparam logic [IDX_W-1:0]      c_last    = IDX_W'(CENTROID_NUM-1);
   localparam logic [ACCUM_CORD_W-1:0] c_acc_max = '1;
   localparam logic [CNT_W-1:0]      c_cnt_max = '1;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [ACCUM_CORD_W-1:0] acc_q [CENTROID_NUM][DIMS];
   logic [ACCUM_CORD_W-1:0] acc_d [CENTROID_NUM][DIMS];
   logic [CNT_W-1:0]        cnt_q [CENTROID_NUM];
   logic [CNT_W-1:0]        cnt_d [CENTROID_NUM];
   logic [CENTROID_NUM-1:0] ovf_q, ovf_d;
   logic                    idx_err_q, idx_err_d;
   logic                    dclr_q, dclr_d;
   logic [IDX_W-1:0]        ptr_q, ptr_d;

   logic                    accept;
   logic                    idx_ok;
   logic [ACCUM_CORD_W-1:0] acc_sel [DIMS];
   logic [CNT_W-1:0]        cnt_sel;
   logic [ACCUM_CORD_W-1:0] acc_new [DIMS];
   logic [DIMS-1:0]         sat;
   logic                    cnt_sat;

   assign accept = bus.in_valid && bus.in_ready;
   assign idx_ok = {1'b0, bus.in_index} < c_num;

   // Only the addressed centroid is summed, so one adder per coordinate suffices.
   always_comb begin
      acc_sel = '{default: '0};
      cnt_sel = '0;
      for (int c = 0; c < CENTROID_NUM; c++) begin
         if (bus.in_index == IDX_W'(c)) begin
            acc_sel = acc_q[c];
            cnt_sel = cnt_q[c];
         end
      end
   end

   for (genvar d = 0; d < DIMS; d++) begin : g_dim
      logic [ACCUM_CORD_W:0] sum_w;
      assign sum_w      = {1'b0, acc_sel[d]} + (ACCUM_CORD_W+1)'(bus.in_point[d*COORD_W +: COORD_W]);
      assign sat[d]     = sum_w[ACCUM_CORD_W];
      assign acc_new[d] = sat[d] ? c_acc_max : sum_w[ACCUM_CORD_W-1:0];
   end

   assign cnt_sat = (cnt_sel == c_cnt_max);

   always_comb begin
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      idx_err_d = idx_err_q;
      state_d   = state_q;
      ptr_d     = ptr_q;
      dclr_d    = dclr_q;
      if (clear) begin
         acc_d     = '{default: '{default: '0}};
         cnt_d     = '{default: '0};
         ovf_d     = '0;
         idx_err_d = 1'b0;
         state_d   = ACCUM;
         ptr_d     = '0;
         dclr_d    = 1'b0;
      end else begin
         if (accept) begin
            if (!idx_ok) begin
               idx_err_d = 1'b1;
            end else begin
               for (int c = 0; c < CENTROID_NUM; c++) begin
                  if (bus.in_index == IDX_W'(c)) begin
                     acc_d[c] = acc_new;
                     cnt_d[c] = cnt_sat ? cnt_q[c] : cnt_q[c] + CNT_W'(1);
                     if ((|sat) || cnt_sat) ovf_d[c] = 1'b1;
                  end
               end
            end
         end
         case (state_q)
            ACCUM: begin
               if (drain_req) begin
                  state_d = DRAIN;
                  ptr_d   = '0;
                  dclr_d  = drain_clear;
               end
            end
            DRAIN: begin
               if (bus.out_ready) begin
                  if (ptr_q == c_last) begin
                     state_d = ACCUM;
                     ptr_d   = '0;
                     if (dclr_q) begin
                        acc_d = '{default: '{default: '0}};
                        cnt_d = '{default: '0};
                        ovf_d = '0;
                     end
                  end else begin
                     ptr_d = ptr_q + IDX_W'(1);
                  end
               end
            end
            default: state_d = ACCUM;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ACCUM;
         ptr_q     <= '0;
         dclr_q    <= 1'b0;
         ovf_q     <= '0;
         idx_err_q <= 1'b0;
         for (int c = 0; c < CENTROID_NUM; c++) begin
            cnt_q[c] <= '0;
            for (int d = 0; d < DIMS; d++) acc_q[c][d] <= '0;
         end
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         dclr_q    <= dclr_d;
         ovf_q     <= ovf_d;
         idx_err_q <= idx_err_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
      end
   end

   assign busy          = (state_q == DRAIN);
   assign bus.in_ready  = (state_q == ACCUM) && !rst;
   assign bus.out_valid = busy;
   assign bus.out_last  = busy && (ptr_q == c_last);
   assign bus.out_index = busy ? ptr_q : '0;
   assign ovf_flags     = ovf_q;
   assign idx_err       = idx_err_q;

   always_comb begin
      bus.out_accum = '0;
      bus.out_count = '0;
      for (int c = 0; c < CENTROID_NUM; c++) begin
         if (busy && ptr_q == IDX_W'(c)) begin
            bus.out_count = cnt_q[c];
            for (int d = 0; d < DIMS; d++) bus.out_accum[d*ACCUM_CORD_W +: ACCUM_CORD_W] = acc_q[c][d];
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_classify_accum_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_classify_accum_bank : randomized bench with array-based bank model    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_classify_accum_bank;
   localparam int CN = 8, DIMS = 7, CW = 13, AW = 22, NW = 10, IW = 4;
   localparam longint ACC_MAX = (longint'(1) << AW) - 1;
   localparam int     CNT_MAX = (1 << NW) - 1;

   logic clk = 1'b0, rst = 1'b1, clear = 1'b0, drain_req = 1'b0, drain_clear = 1'b0;
   logic [CN-1:0] ovf_flags;
   logic idx_err, busy;

   classify_accum_bank_if #(.DIMS(DIMS), .COORD_W(CW), .ACCUM_CORD_W(AW), .CNT_W(NW), .IDX_W(IW)) bif();

   classify_accum_bank #(.CENTROID_NUM(CN), .DIMS(DIMS), .COORD_W(CW), .ACCUM_CORD_W(AW),
                         .CNT_W(NW), .IDX_W(IW)) dut (
      .clk(clk), .rst(rst), .bus(bif), .clear(clear), .drain_req(drain_req),
      .drain_clear(drain_clear), .ovf_flags(ovf_flags), .idx_err(idx_err), .busy(busy));

   always #5 clk = ~clk;

   int checks = 0, failures = 0;

   longint m_acc [CN][DIMS];
   int     m_cnt [CN];
   bit     m_ovf [CN];
   bit     m_idx_err;

   function automatic void m_clear(input bit with_idx_err);
      for (int c = 0; c < CN; c++) begin
         m_cnt[c] = 0;
         m_ovf[c] = 1'b0;
         for (int d = 0; d < DIMS; d++) m_acc[c][d] = 0;
      end
      if (with_idx_err) m_idx_err = 1'b0;
   endfunction

   function automatic void m_accept(input int idx, input logic [DIMS*CW-1:0] p);
      if (idx >= CN) begin
         m_idx_err = 1'b1;
         return;
      end
      for (int d = 0; d < DIMS; d++) begin
         longint s;
         s = m_acc[idx][d] + longint'(p[d*CW +: CW]);
         if (s > ACC_MAX) begin
            s = ACC_MAX;
            m_ovf[idx] = 1'b1;
         end
         m_acc[idx][d] = s;
      end
      if (m_cnt[idx] == CNT_MAX) m_ovf[idx] = 1'b1;
      else m_cnt[idx] = m_cnt[idx] + 1;
   endfunction

   function automatic logic [CN-1:0] m_ovf_vec();
      logic [CN-1:0] v;
      for (int c = 0; c < CN; c++) v[c] = m_ovf[c];
      return v;
   endfunction

   function automatic logic [DIMS*CW-1:0] fill(input int v);
      logic [DIMS*CW-1:0] p;
      for (int d = 0; d < DIMS; d++) p[d*CW +: CW] = CW'(v);
      return p;
   endfunction

   function automatic logic [DIMS*CW-1:0] rand_point();
      logic [DIMS*CW-1:0] p;
      for (int d = 0; d < DIMS; d++) p[d*CW +: CW] = CW'($urandom);
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int idx, input logic [DIMS*CW-1:0] p);
      bif.in_valid = 1'b1;
      bif.in_index = IW'(idx);
      bif.in_point = p;
      tick();
      m_accept(idx, p);
      bif.in_valid = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      m_clear(1'b1);
   endtask

   // Streams a full drain and compares every presented beat with the model.
   task automatic test_drain_stream(input bit dclr, input int mode, input bit with_pt,
                                    input int pidx, input logic [DIMS*CW-1:0] p);
      int beat = 0, cyc = 0;
      bit rdy;
      logic [DIMS*AW-1:0] exp_acc;
      bif.out_ready = 1'b0;
      drain_req     = 1'b1;
      drain_clear   = dclr;
      if (with_pt) begin
         bif.in_valid = 1'b1;
         bif.in_index = IW'(pidx);
         bif.in_point = p;
      end
      tick();
      if (with_pt) m_accept(pidx, p);
      bif.in_valid = 1'b0;
      drain_req    = 1'b0;
      drain_clear  = 1'b0;
      while (beat < CN && cyc < 200) begin
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 2 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         bif.out_ready = rdy;
         bif.in_valid  = 1'($urandom_range(0, 1));
         bif.in_index  = IW'($urandom_range(0, CN-1));
         bif.in_point  = rand_point();
         drain_req     = 1'($urandom_range(0, 1));
         for (int d = 0; d < DIMS; d++) exp_acc[d*AW +: AW] = AW'(m_acc[beat][d]);
         checks++;
         if ({bif.out_valid, busy, bif.in_ready} !== 3'b110) begin
            failures++;
            $display("FAIL drain_status beat %0d: got v/b/r=%b expected 110", beat, {bif.out_valid, busy, bif.in_ready});
         end
         checks++;
         if (bif.out_index !== IW'(beat)) begin
            failures++;
            $display("FAIL drain_index: got %0d expected %0d", bif.out_index, beat);
         end
         checks++;
         if (bif.out_accum !== exp_acc) begin
            failures++;
            $display("FAIL drain_accum beat %0d: got %h expected %h", beat, bif.out_accum, exp_acc);
         end
         checks++;
         if (bif.out_count !== NW'(m_cnt[beat])) begin
            failures++;
            $display("FAIL drain_count beat %0d: got %0d expected %0d", beat, bif.out_count, m_cnt[beat]);
         end
         checks++;
         if (bif.out_last !== (beat == CN-1)) begin
            failures++;
            $display("FAIL drain_last beat %0d: got %b expected %b", beat, bif.out_last, beat == CN-1);
         end
         tick();
         if (rdy) beat++;
         cyc++;
      end
      bif.out_ready = 1'b0;
      bif.in_valid  = 1'b0;
      drain_req     = 1'b0;
      checks++;
      if (beat != CN) begin
         failures++;
         $display("FAIL drain_timeout: got %0d beats expected %0d", beat, CN);
      end
      if (dclr) m_clear(1'b0);
      checks++;
      if ({bif.out_valid, busy, bif.in_ready} !== 3'b001) begin
         failures++;
         $display("FAIL drain_done_status: got v/b/r=%b expected 001", {bif.out_valid, busy, bif.in_ready});
      end
      checks++;
      if (ovf_flags !== m_ovf_vec()) begin
         failures++;
         $display("FAIL drain_ovf: got %b expected %b", ovf_flags, m_ovf_vec());
      end
      checks++;
      if (idx_err !== m_idx_err) begin
         failures++;
         $display("FAIL drain_idx_err: got %b expected %b", idx_err, m_idx_err);
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({bif.in_ready, bif.out_valid, busy, bif.out_last, idx_err} !== 5'b0) begin
         failures++;
         $display("FAIL reset_ctrl: got r/v/b/l/e=%b expected 00000",
                  {bif.in_ready, bif.out_valid, busy, bif.out_last, idx_err});
      end
      checks++;
      if (ovf_flags !== '0) begin
         failures++;
         $display("FAIL reset_ovf: got %b expected 0", ovf_flags);
      end
      checks++;
      if (bif.out_index !== '0 || bif.out_count !== '0 || bif.out_accum !== '0) begin
         failures++;
         $display("FAIL reset_data: got idx=%0d cnt=%0d acc=%h expected all 0", bif.out_index, bif.out_count, bif.out_accum);
      end
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (bif.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_ready: got %b expected 1", bif.in_ready);
      end
      m_clear(1'b1);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) send(2, fill(5));
      test_drain_stream(1'b0, 0, 1'b0, 0, '0);
   endtask

   task automatic test_saturation();
      logic [DIMS*CW-1:0] p;
      do_clear();
      p = fill(1);
      p[CW-1:0] = CW'(8191);
      for (int i = 0; i < 512; i++) send(0, p);
      checks++;
      if (ovf_flags !== m_ovf_vec()) begin
         failures++;
         $display("FAIL sat_acc_pre: got %b expected %b", ovf_flags, m_ovf_vec());
      end
      send(0, p);
      checks++;
      if (ovf_flags !== m_ovf_vec()) begin
         failures++;
         $display("FAIL sat_acc_post: got %b expected %b", ovf_flags, m_ovf_vec());
      end
      test_drain_stream(1'b1, 2, 1'b0, 0, '0);
      for (int i = 0; i < CNT_MAX; i++) send(4, fill(0));
      checks++;
      if (ovf_flags !== m_ovf_vec()) begin
         failures++;
         $display("FAIL sat_cnt_pre: got %b expected %b", ovf_flags, m_ovf_vec());
      end
      send(4, fill(0));
      checks++;
      if (ovf_flags !== m_ovf_vec()) begin
         failures++;
         $display("FAIL sat_cnt_post: got %b expected %b", ovf_flags, m_ovf_vec());
      end
      test_drain_stream(1'b0, 0, 1'b0, 0, '0);
   endtask

   task automatic test_drain_clear();
      do_clear();
      for (int i = 0; i < 4; i++) send(1, fill(1));
      for (int i = 0; i < 2; i++) send(7, fill(2));
      test_drain_stream(1'b1, 1, 1'b0, 0, '0);
      test_drain_stream(1'b0, 0, 1'b0, 0, '0);
   endtask

   task automatic test_idx_err();
      do_clear();
      send(6, fill(7));
      bif.in_valid = 1'b1;
      bif.in_index = IW'(9);
      bif.in_point = rand_point();
      #1;
      checks++;
      if (bif.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL idx_err_handshake: got in_ready=%b expected 1", bif.in_ready);
      end
      tick();
      m_accept(9, bif.in_point);
      bif.in_valid = 1'b0;
      checks++;
      if (idx_err !== m_idx_err) begin
         failures++;
         $display("FAIL idx_err_flag: got %b expected %b", idx_err, m_idx_err);
      end
      test_drain_stream(1'b1, 2, 1'b0, 0, '0);
   endtask

   task automatic test_clear();
      do_clear();
      send(3, fill(4));
      clear = 1'b1;
      bif.in_valid = 1'b1;
      bif.in_index = IW'(3);
      bif.in_point = fill(9);
      tick();
      clear = 1'b0;
      bif.in_valid = 1'b0;
      m_clear(1'b1);
      test_drain_stream(1'b0, 0, 1'b0, 0, '0);
      send(4, fill(1));
      send(9, fill(1));
      drain_req = 1'b1;
      tick();
      drain_req = 1'b0;
      bif.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (bif.out_index !== IW'(4) || bif.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL clear_mid_pos: got idx=%0d valid=%b expected idx=4 valid=1", bif.out_index, bif.out_valid);
      end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      bif.out_ready = 1'b0;
      m_clear(1'b1);
      checks++;
      if ({bif.out_valid, busy, bif.in_ready, idx_err} !== 4'b0010) begin
         failures++;
         $display("FAIL clear_mid_abort: got v/b/r/e=%b expected 0010", {bif.out_valid, busy, bif.in_ready, idx_err});
      end
      test_drain_stream(1'b0, 2, 1'b0, 0, '0);
   endtask

   task automatic test_drain_with_accept();
      do_clear();
      test_drain_stream(1'b0, 1, 1'b1, 5, fill(3));
      test_drain_stream(1'b0, 2, 1'b0, 0, '0);
   endtask

   task automatic test_random();
      do_clear();
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) tick();
         else send(int'($urandom_range(0, 15)), rand_point());
         if (i % 100 == 99) test_drain_stream(1'($urandom_range(0, 1)), 2, 1'b0, 0, '0);
      end
      test_drain_stream(1'b0, 2, 1'b1, int'($urandom_range(0, CN-1)), rand_point());
   endtask

   task automatic test_reset_mid();
      send(2, fill(8));
      send(12, fill(1));
      drain_req = 1'b1;
      tick();
      drain_req = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if ({bif.out_valid, busy, bif.in_ready, idx_err} !== 4'b0000 || ovf_flags !== '0) begin
         failures++;
         $display("FAIL reset_mid: got v/b/r/e=%b ovf=%b expected all 0", {bif.out_valid, busy, bif.in_ready, idx_err}, ovf_flags);
      end
      m_clear(1'b1);
      tick();
      rst = 1'b0;
      test_drain_stream(1'b0, 0, 1'b0, 0, '0);
   endtask

   initial begin
      bif.in_valid  = 1'b0;
      bif.in_index  = '0;
      bif.in_point  = '0;
      bif.out_ready = 1'b0;
      m_clear(1'b1);
      test_reset();
      test_back_to_back();
      test_saturation();
      test_drain_clear();
      test_idx_err();
      test_clear();
      test_drain_with_accept();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end
endmodule
`default_nettype wire

// File: doc/classify_accum_bank.md
Name: classify_accum_bank

Overview:
- Parametrised per-centroid accumulator bank for the k-means classify pipeline.
- Sits after the distance/argmin stage. Each accepted (index, point) pair adds the point's coordinates into that centroid's accumulator and increments its count.
- Generalises centroid count, dimension and widths. Adds valid/ready handshakes, saturating arithmetic with sticky overflow flags, out-of-range index detection, and a serial drain FSM that streams per-centroid sums and counts to the centroid-update stage.

Parameters:
CENTROID_NUM, 8, number of centroids / accumulator channels (2..16)
DIMS, 7, coordinates per point
COORD_W, 13, unsigned coordinate width
ACCUM_CORD_W, 22, per-coordinate accumulator width (> COORD_W)
CNT_W, 10, per-centroid counter width
IDX_W, 4, index width; must satisfy 2**IDX_W >= CENTROID_NUM

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  point/index valid
in_ready  out  1  bank can accept a point
in_index  in  IDX_W  target centroid, 0-based
in_point  in  DIMS*COORD_W  packed coords, coord d at [d*COORD_W +: COORD_W]
clear  in  1  synchronous clear of all accumulators, counts and flags
drain_req  in  1  single-cycle pulse: start drain
drain_clear  in  1  sampled with drain_req: clear bank after drain
out_valid  out  1  drain beat valid
out_ready  in  1  downstream accepts beat
out_index  out  IDX_W  centroid of current beat
out_accum  out  DIMS*ACCUM_CORD_W  packed sums for out_index
out_count  out  CNT_W  count for out_index
out_last  out  1  beat is centroid CENTROID_NUM-1
ovf_flags  out  CENTROID_NUM  sticky per-centroid saturation flags
idx_err  out  1  sticky: point presented with in_index >= CENTROID_NUM
busy  out  1  FSM in DRAIN

Behaviour:
- State reset (rst high, async): all accumulators, counters, ovf_flags and idx_err are 0; FSM is ACCUM; drain pointer is 0; the drain_clear latch is 0.
- Output reset values: in_ready=0 while rst is asserted; out_valid=0; out_last=0; busy=0; out_index=0; out_accum=0; out_count=0.
- FSM has two states, ACCUM and DRAIN.
- ACCUM: in_ready=1 (when rst is low), out_valid=0.
  - A point is accepted on a rising edge with in_valid and in_ready.
  - The sum and count update on that same edge, so they are visible on the following cycle (1-cycle latency).
  - Back-to-back accepts to the same index every cycle must accumulate correctly, with no hazard.
- Arithmetic per coordinate:
  - acc_d <= min(acc_d + zero_ext(coord_d), 2**ACCUM_CORD_W - 1).
  - Counter: cnt <= min(cnt + 1, 2**CNT_W - 1).
  - Any clamp (any coordinate or the counter) sets ovf_flags[index]. The flag is sticky until clear or rst.
- in_index >= CENTROID_NUM: the point is accepted (handshake completes), no register changes, idx_err is set (sticky).
- drain_req in ACCUM:
  - Next state is DRAIN, pointer=0, drain_clear latched.
  - If a point is accepted on the same edge, it is included in the sums.
  - in_ready drops from the next cycle.
- DRAIN:
  - in_ready=0, busy=1, out_valid=1.
  - out_index = pointer; out_accum and out_count are driven from the registers at the pointer.
  - out_last = (pointer == CENTROID_NUM-1).
  - Data must hold stable while out_valid && !out_ready.
  - On a beat accept (out_valid && out_ready): pointer increments.
  - On the last beat: return to ACCUM. If the latch is set, also clear all accumulators, counters and ovf_flags on that edge; idx_err is kept.
- drain_req while in DRAIN: ignored.
- clear (any state): on that edge, all accumulators, counters, ovf_flags and idx_err go to 0, FSM returns to ACCUM, and pointer goes to 0.
  - clear takes priority over a simultaneous point accept: the point is consumed and discarded.
  - clear takes priority over drain_req and over beat accept.
  - clear in DRAIN aborts the drain; out_valid is 0 on the next cycle.
- rst mid-operation: immediate return to reset values, regardless of state or handshakes.

Test Plan:
- Reset, then accept index 2 with all coords=5 for 3 consecutive cycles -> accumulator 2 = 15 per coord, count 2 = 3, others 0; ovf_flags=0.
- Accept index 0 with coord 0=8191 repeatedly, ACCUM_CORD_W=22 -> after 513 accepts coord 0 clamps at 4194303 and ovf_flags[0]=1; other coords are unaffected by the clamp.
- Load index 1 (coords=1, x4) and index 7 (coords=2, x2). Pulse drain_req with drain_clear=1, out_ready toggling 1/0 -> 8 beats in order 0..7; beat 1 = sums 4/count 4, beat 7 = sums 4/count 2 with out_last=1; data stable on stalls; afterwards all zero and in_ready=1.
- in_valid with in_index=9, CENTROID_NUM=8 -> idx_err=1, all sums/counts unchanged, handshake completes.
- clear asserted in the same cycle as an accept to index 3 -> count 3 = 0, sums 0. clear in the middle of a drain at beat 4 -> out_valid=0 next cycle, FSM in ACCUM.
- drain_req in the same cycle as an accept to index 5 (coords=3) with drain_clear=0 -> beat 5 shows sums 3/count 1; after the drain, registers are retained.
